// File: rtl/puf_challenge_sequencer.sv
// Purpose: drives a PUF with successive LFSR challenges, packs the 1-bit responses into a word.
// Latency: SETTLE_CYCLES+2 cycles per bit; word valid RESP_BITS*(SETTLE_CYCLES+2) cycles after launch.
// Backpressure: resp_word/resp_valid held in OUTPUT until resp_ready; no LFSR or PUF activity meanwhile.
module puf_challenge_sequencer #(
    parameter int CHAL_WIDTH    = 8,
    parameter int RESP_BITS     = 16,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [CHAL_WIDTH-1:0] challenge_in,
    output logic                  increment,
    output logic [CHAL_WIDTH-1:0] puf_challenge,
    output logic                  puf_enable,
    input  logic                  puf_response,
    output logic [RESP_BITS-1:0]  resp_word,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  busy,
    output logic [7:0]            word_count
);

    localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int BCW = $clog2(RESP_BITS);
    localparam logic [SCW-1:0] SETTLE_LOAD = SCW'(SETTLE_CYCLES - 1);
    localparam logic [BCW-1:0] LAST_BIT    = BCW'(RESP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        SETTLE,
        CAPTURE,
        OUTPUT
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [SCW-1:0]       settle_cnt;
    logic [BCW-1:0]       bit_cnt;
    logic [RESP_BITS-1:0] shreg;

    // State register; reset returns to IDLE regardless of other inputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and Moore outputs decoded from the current state.
    always_comb begin
        state_nxt  = state;
        increment  = 1'b0;
        puf_enable = 1'b0;
        resp_valid = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                state_nxt = SETTLE;
            end
            SETTLE: begin
                puf_enable = 1'b1;
                if (settle_cnt == '0) begin
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                // The LFSR steps on the edge that leaves CAPTURE, so the
                // following LAUNCH sees the fresh challenge.
                increment = 1'b1;
                if (bit_cnt == LAST_BIT) begin
                    state_nxt = OUTPUT;
                end else begin
                    state_nxt = LAUNCH;
                end
            end
            OUTPUT: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: challenge register, settle/bit counters, response shifter, word counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            puf_challenge <= '0;
            settle_cnt    <= '0;
            bit_cnt       <= '0;
            shreg         <= '0;
            word_count    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        bit_cnt <= '0;
                    end
                end
                LAUNCH: begin
                    puf_challenge <= challenge_in;
                    settle_cnt    <= SETTLE_LOAD;
                end
                SETTLE: begin
                    if (settle_cnt != '0) begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                CAPTURE: begin
                    // First captured bit ends up in the MSB after RESP_BITS shifts.
                    shreg   <= {shreg[RESP_BITS-2:0], puf_response};
                    bit_cnt <= bit_cnt + 1'b1;
                end
                OUTPUT: begin
                    if (resp_ready) begin
                        word_count <= word_count + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign resp_word = shreg;

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Bench for puf_challenge_sequencer: a 4-bit-word instance driven from a vector table
// and hand-written corner sequences, plus a default-parameter instance for pulse accounting.
// Both instances are fed by an 8-bit LFSR model (x^8+x^4+x^3+x^2+1) and a PUF stub.
module tb_puf_challenge_sequencer;

    logic        clock = 1'b0;
    logic        reset;

    // Instance A: RESP_BITS=4, SETTLE_CYCLES=4
    logic        start_a, resp_ready_a, inv_a, seed_load_a;
    logic [7:0]  seed_val_a, lfsr_a;
    logic        increment_a, puf_enable_a, resp_valid_a, busy_a, puf_response_a;
    logic [7:0]  puf_challenge_a, word_count_a;
    logic [3:0]  resp_word_a;

    // Instance B: default parameters
    logic        start_b, resp_ready_b, seed_load_b;
    logic [7:0]  seed_val_b, lfsr_b;
    logic        increment_b, puf_enable_b, resp_valid_b, busy_b, puf_response_b;
    logic [7:0]  puf_challenge_b, word_count_b;
    logic [15:0] resp_word_b;

    int checks = 0;
    int errors = 0;
    int exp_wc_a = 0;

    logic [3:0]  sb_a[$];
    logic [15:0] sb_b[$];

    logic [7:0]  chal_exp [4] = '{8'h01, 8'h02, 8'h05, 8'h0B};

    typedef struct {
        logic [7:0] seed;
        logic       inv;
        int         hold;
        bit         spur;
        logic [3:0] exp_word;
    } vec_t;

    vec_t tbl [5];

    always #5 clock = ~clock;

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[3] ^ s[2] ^ s[1]};
    endfunction

    always @(posedge clock) begin
        if (seed_load_a) lfsr_a <= seed_val_a;
        else if (increment_a) lfsr_a <= lfsr_next(lfsr_a);
        if (seed_load_b) lfsr_b <= seed_val_b;
        else if (increment_b) lfsr_b <= lfsr_next(lfsr_b);
    end

    assign puf_response_a = puf_challenge_a[0] ^ inv_a;
    assign puf_response_b = puf_challenge_b[0];

    puf_challenge_sequencer #(.CHAL_WIDTH(8), .RESP_BITS(4), .SETTLE_CYCLES(4)) dut_a (
        .clock(clock), .reset(reset), .start(start_a), .challenge_in(lfsr_a),
        .increment(increment_a), .puf_challenge(puf_challenge_a), .puf_enable(puf_enable_a),
        .puf_response(puf_response_a), .resp_word(resp_word_a), .resp_valid(resp_valid_a),
        .resp_ready(resp_ready_a), .busy(busy_a), .word_count(word_count_a)
    );

    puf_challenge_sequencer dut_b (
        .clock(clock), .reset(reset), .start(start_b), .challenge_in(lfsr_b),
        .increment(increment_b), .puf_challenge(puf_challenge_b), .puf_enable(puf_enable_b),
        .puf_response(puf_response_b), .resp_word(resp_word_b), .resp_valid(resp_valid_b),
        .resp_ready(resp_ready_b), .busy(busy_b), .word_count(word_count_b)
    );

    // Pulse accounting on instance B: every increment must be a single cycle
    // immediately preceded by exactly 4 puf_enable cycles.
    int pulses_b = 0;
    int bad_b    = 0;
    int en_run_b = 0;
    bit prev_inc_b = 1'b0;
    always @(negedge clock) begin
        prev_inc_b <= increment_b;
        if (increment_b) begin
            pulses_b <= pulses_b + 1;
            if (en_run_b != 4 || prev_inc_b) bad_b <= bad_b + 1;
            en_run_b <= 0;
        end else if (puf_enable_b) begin
            en_run_b <= en_run_b + 1;
        end else begin
            en_run_b <= 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic seed_a(input logic [7:0] s);
        seed_val_a  = s;
        seed_load_a = 1'b1;
        @(posedge clock); #1;
        seed_load_a = 1'b0;
    endtask

    // One word on instance A: push expectation, pulse start, wait for valid,
    // optionally stall ready, then complete the handshake.
    task automatic word_a(input logic [3:0] exp, input int hold, input bit chk, input bit spur);
        logic [7:0] seen[$];
        logic [3:0] w0, got;
        int cyc;
        bit bad;
        sb_a.push_back(exp);
        start_a = 1'b1;
        cyc = 0;
        while (cyc < 100) begin
            @(posedge clock); #1;
            cyc++;
            start_a = 1'b0;
            if (resp_valid_a) break;
            if (increment_a) seen.push_back(puf_challenge_a);
            if (spur && (puf_enable_a || increment_a) && (cyc % 3 == 0)) start_a = 1'b1;
        end
        if (!resp_valid_a) begin
            checks++;
            errors++;
            $display("FAIL valid_timeout_a: resp_valid still 0 after %0d cycles, required 1", cyc);
            sb_a.delete();
            return;
        end
        if (chk) begin
            check("latency_edges", cyc, 25);
            check("chal_count", seen.size(), 4);
            for (int i = 0; i < 4 && i < seen.size(); i++) check("chal_seq", seen[i], chal_exp[i]);
        end
        got = sb_a.pop_front();
        check("resp_word_a", resp_word_a, got);
        w0  = resp_word_a;
        bad = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clock); #1;
            if (!resp_valid_a || resp_word_a != w0 || increment_a || puf_enable_a || !busy_a) bad = 1'b1;
        end
        if (hold > 0) check("backpressure_hold", bad, 0);
        resp_ready_a = 1'b1;
        @(posedge clock); #1;
        resp_ready_a = 1'b0;
        check("valid_drop_a", {resp_valid_a, busy_a, increment_a}, 0);
        exp_wc_a++;
        check("word_count_a", word_count_a, exp_wc_a);
        check("word_hold_idle", resp_word_a, got);
    endtask

    initial begin
        begin : main
            int n;
            int cyc;
            logic [7:0]  s;
            logic [15:0] e;
            logic [3:0]  got_a;
            logic [15:0] got_b;

            tbl[0] = '{seed: 8'h01, inv: 1'b0, hold: 0,  spur: 1'b0, exp_word: 4'hB};
            tbl[1] = '{seed: 8'h80, inv: 1'b0, hold: 10, spur: 1'b0, exp_word: 4'h5};
            tbl[2] = '{seed: 8'hFF, inv: 1'b0, hold: 0,  spur: 1'b1, exp_word: 4'h9};
            tbl[3] = '{seed: 8'h0B, inv: 1'b0, hold: 3,  spur: 1'b1, exp_word: 4'h8};
            tbl[4] = '{seed: 8'h01, inv: 1'b1, hold: 0,  spur: 1'b0, exp_word: 4'h4};

            reset = 1'b1;
            start_a = 1'b1; start_b = 1'b1;
            resp_ready_a = 1'b0; resp_ready_b = 1'b1;
            inv_a = 1'b0;
            seed_val_a = 8'h01; seed_load_a = 1'b1;
            seed_val_b = 8'h01; seed_load_b = 1'b1;

            // Reset held 3 cycles with start high
            for (int i = 0; i < 3; i++) begin
                @(posedge clock); #1;
                check("reset_outs_a", {increment_a, puf_enable_a, resp_valid_a, busy_a,
                                       puf_challenge_a, resp_word_a, word_count_a}, 0);
                check("reset_outs_b", {increment_b, puf_enable_b, resp_valid_b, busy_b,
                                       puf_challenge_b, resp_word_b, word_count_b}, 0);
            end
            reset = 1'b0;
            start_a = 1'b0; start_b = 1'b0;
            seed_load_a = 1'b0; seed_load_b = 1'b0;

            // Table-driven words on instance A
            for (int i = 0; i < 5; i++) begin
                seed_a(tbl[i].seed);
                inv_a = tbl[i].inv;
                word_a(tbl[i].exp_word, tbl[i].hold, (i == 0), tbl[i].spur);
            end
            inv_a = 1'b0;

            // Reset in the middle of SETTLE during bit 2
            seed_a(8'h01);
            start_a = 1'b1;
            @(posedge clock); #1;
            start_a = 1'b0;
            n = 0;
            cyc = 0;
            while (cyc < 100 && !(n == 2 && puf_enable_a)) begin
                @(posedge clock); #1;
                cyc++;
                if (increment_a) n++;
            end
            check("midreset_reached_settle", {n[7:0], puf_enable_a}, {8'd2, 1'b1});
            reset = 1'b1;
            @(posedge clock); #1;
            reset = 1'b0;
            check("midreset_outs", {increment_a, puf_enable_a, resp_valid_a, busy_a,
                                    puf_challenge_a, resp_word_a, word_count_a}, 0);
            exp_wc_a = 0;
            seed_a(8'h01);
            word_a(4'hB, 0, 1'b1, 1'b0);

            // start held high across the handshake
            seed_a(8'h01);
            sb_a.push_back(4'hB);
            start_a = 1'b1;
            cyc = 0;
            while (cyc < 100 && !resp_valid_a) begin
                @(posedge clock); #1;
                cyc++;
            end
            check("held_valid_seen", resp_valid_a, 1);
            got_a = sb_a.pop_front();
            check("held_resp_word", resp_word_a, got_a);
            resp_ready_a = 1'b1;
            @(posedge clock); #1;
            resp_ready_a = 1'b0;
            check("held_valid_drop", {resp_valid_a, busy_a}, 0);
            exp_wc_a++;
            check("held_word_count", word_count_a, exp_wc_a);
            @(posedge clock); #1;
            check("held_busy_again", busy_a, 1);
            start_a = 1'b0;
            reset = 1'b1;
            @(posedge clock); #1;
            reset = 1'b0;
            exp_wc_a = 0;

            // Instance B: three default-size words back to back
            seed_val_b  = 8'h01;
            seed_load_b = 1'b1;
            @(posedge clock); #1;
            seed_load_b = 1'b0;
            s = 8'h01;
            for (int w = 0; w < 3; w++) begin
                e = '0;
                for (int j = 0; j < 16; j++) begin
                    e = {e[14:0], s[0]};
                    s = lfsr_next(s);
                end
                sb_b.push_back(e);
                start_b = 1'b1;
                cyc = 0;
                while (cyc < 300) begin
                    @(posedge clock); #1;
                    cyc++;
                    start_b = 1'b0;
                    if (resp_valid_b) break;
                end
                if (!resp_valid_b) begin
                    checks++;
                    errors++;
                    $display("FAIL valid_timeout_b: resp_valid still 0 after %0d cycles, required 1", cyc);
                    sb_b.delete();
                end else begin
                    got_b = sb_b.pop_front();
                    check("resp_word_b", resp_word_b, got_b);
                end
                @(posedge clock); #1;
            end
            @(posedge clock); #1;
            check("increment_pulses_b", pulses_b, 48);
            check("pulse_shape_b", bad_b, 0);
            check("word_count_b", word_count_b, 3);
            check("idle_after_b", {busy_b, resp_valid_b}, 0);

            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
